// File: rtl/metro_pkg.sv
// Shared types and constants for the ticket/change dispensing stage.
package metro_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TICKET,
    COIN,
    DONE,
    FAULT
  } state_t;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_TKT  = 2'b01;
  localparam logic [1:0] FAULT_COIN = 2'b10;

  localparam int DEFAULT_TIMEOUT = 1000;
  localparam int DEFAULT_TW      = 16;

endpackage

// File: rtl/metro_sense_sync.sv
// Two-flop synchroniser for a mechanism sensor followed by a registered
// rising-edge detector; a level held high yields a single one-cycle pulse.
module metro_sense_sync (
  input  logic clk,
  input  logic rst,
  input  logic sense,
  output logic pulse
);

  logic meta;
  logic stable;
  logic stable_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      meta     <= sense;
      stable   <= meta;
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/metro_dispenser.sv
// Dispenses a confirmed sale: prints tickets, then pays out 1-yuan coins,
// confirming every item by sensor and latching a fault on a missing confirmation.
module metro_dispenser
  import metro_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TW      = DEFAULT_TW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] ticket_cnt,
  input  logic [7:0] change_amt,
  input  logic       tkt_sense,
  input  logic       coin_sense,
  input  logic       clear,
  output logic       tkt_en,
  output logic       hopper_en,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] tickets_left,
  output logic [7:0] coins_left
);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          tkt_pulse;
  logic          coin_pulse;

  metro_sense_sync u_tkt_sync (
    .clk   (clk),
    .rst   (rst),
    .sense (tkt_sense),
    .pulse (tkt_pulse)
  );

  metro_sense_sync u_coin_sync (
    .clk   (clk),
    .rst   (rst),
    .sense (coin_sense),
    .pulse (coin_pulse)
  );

  // Decoded straight from the state register so reset stops the motors at once.
  assign tkt_en    = (state == TICKET);
  assign hopper_en = (state == COIN);
  assign busy      = (state != IDLE);
  assign fault     = (state == FAULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      tickets_left <= '0;
      coins_left   <= '0;
      fault_code   <= FAULT_NONE;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tickets_left <= ticket_cnt;
            coins_left   <= change_amt;
            timer        <= '0;
            if (ticket_cnt != '0) begin
              state <= TICKET;
            end else if (change_amt != '0) begin
              state <= COIN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        // A confirmation in the timeout cycle takes priority over the fault.
        TICKET: begin
          if (tkt_pulse) begin
            tickets_left <= tickets_left - 3'd1;
            timer        <= '0;
            if (tickets_left == 3'd1) begin
              if (coins_left != '0) begin
                state <= COIN;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end else if (timer == TIMER_LAST) begin
            state      <= FAULT;
            fault_code <= FAULT_TKT;
          end else begin
            timer <= (&timer) ? timer : timer + 1'b1;
          end
        end

        COIN: begin
          if (coin_pulse) begin
            coins_left <= coins_left - 8'd1;
            timer      <= '0;
            if (coins_left == 8'd1) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (timer == TIMER_LAST) begin
            state      <= FAULT;
            fault_code <= FAULT_COIN;
          end else begin
            timer <= (&timer) ? timer : timer + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        FAULT: begin
          if (clear) begin
            state        <= IDLE;
            fault_code   <= FAULT_NONE;
            tickets_left <= '0;
            coins_left   <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_metro_dispenser.sv
// Bench for metro_dispenser: directed scenarios plus random sensor traffic,
// every cycle compared against a behavioural model of the dispensing rules.
module tb_metro_dispenser;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] ticket_cnt = '0;
  logic [7:0] change_amt = '0;
  logic       tkt_sense = 1'b0;
  logic       coin_sense = 1'b0;
  logic       clear = 1'b0;
  logic       tkt_en, hopper_en, busy, done, fault;
  logic [1:0] fault_code;
  logic [2:0] tickets_left;
  logic [7:0] coins_left;

  always #5 clk = ~clk;

  metro_dispenser #(.TIMEOUT(TO), .TW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ticket_cnt   (ticket_cnt),
    .change_amt   (change_amt),
    .tkt_sense    (tkt_sense),
    .coin_sense   (coin_sense),
    .clear        (clear),
    .tkt_en       (tkt_en),
    .hopper_en    (hopper_en),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code),
    .tickets_left (tickets_left),
    .coins_left   (coins_left)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Behavioural model: modes, remaining items and cycles elapsed without a confirmation.
  localparam int M_IDLE = 0, M_TKT = 1, M_COIN = 2, M_DONE = 3, M_FAULT = 4;
  int m_mode = M_IDLE, m_tl = 0, m_cl = 0, m_fc = 0, m_wait = 0;
  bit th[4];
  bit ch[4];

  task automatic model_step();
    bit tev, cev;
    if (rst) begin
      m_mode = M_IDLE; m_tl = 0; m_cl = 0; m_fc = 0; m_wait = 0;
      for (int i = 0; i < 4; i++) begin th[i] = 0; ch[i] = 0; end
      return;
    end
    // A rise seen at edge K is acted on at edge K+3.
    tev = th[2] && !th[3];
    cev = ch[2] && !ch[3];
    for (int i = 3; i > 0; i--) begin th[i] = th[i-1]; ch[i] = ch[i-1]; end
    th[0] = tkt_sense;
    ch[0] = coin_sense;
    case (m_mode)
      M_IDLE: if (start) begin
        m_tl = ticket_cnt; m_cl = change_amt; m_wait = 0;
        m_mode = (m_tl > 0) ? M_TKT : (m_cl > 0) ? M_COIN : M_DONE;
      end
      M_TKT: begin
        m_wait++;
        if (tev) begin
          m_tl--; m_wait = 0;
          if (m_tl == 0) m_mode = (m_cl > 0) ? M_COIN : M_DONE;
        end else if (m_wait == TO) begin
          m_mode = M_FAULT; m_fc = 1;
        end
      end
      M_COIN: begin
        m_wait++;
        if (cev) begin
          m_cl--; m_wait = 0;
          if (m_cl == 0) m_mode = M_DONE;
        end else if (m_wait == TO) begin
          m_mode = M_FAULT; m_fc = 2;
        end
      end
      M_DONE: m_mode = M_IDLE;
      default: if (clear) begin
        m_mode = M_IDLE; m_fc = 0; m_tl = 0; m_cl = 0;
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  logic [17:0] dut_vec, exp_vec;
  assign dut_vec = {tkt_en, hopper_en, busy, done, fault, fault_code, tickets_left, coins_left};

  initial forever begin
    @(negedge clk);
    exp_vec = {m_mode == M_TKT, m_mode == M_COIN, m_mode != M_IDLE, m_mode == M_DONE,
               m_mode == M_FAULT, 2'(m_fc), 3'(m_tl), 8'(m_cl)};
    check_val("cycle", 32'(dut_vec), 32'(exp_vec));
    if (done) done_seen++;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(int tc, int ca);
    start = 1'b1; ticket_cnt = 3'(tc); change_amt = 8'(ca);
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse(bit coin, int len);
    if (coin) coin_sense = 1'b1; else tkt_sense = 1'b1;
    tick(len);
    coin_sense = 1'b0; tkt_sense = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int d0;
    tick(3);
    check_val("reset_outputs", 32'(dut_vec), 32'd0);
    rst = 1'b0;
    tick(2);

    // Zero request: done in the cycle right after start.
    do_start(0, 0);
    check_val("zero_done", done, 1);
    check_val("zero_tkt_en", tkt_en, 0);
    tick(1);
    check_val("zero_done_drop", done, 0);
    check_val("zero_busy", busy, 0);

    // Normal sale 2 tickets, 3 coins.
    d0 = done_seen;
    do_start(2, 3);
    check_val("sale_tickets", tickets_left, 2);
    check_val("sale_tkt_en", tkt_en, 1);
    repeat (2) begin tick(20); pulse(0, 1); end
    tick(5);
    check_val("sale_tickets_zero", tickets_left, 0);
    check_val("sale_hopper_en", {tkt_en, hopper_en}, 2'b01);
    repeat (3) begin tick(20); pulse(1, 1); end
    tick(10);
    check_val("sale_done_count", done_seen - d0, 1);
    check_val("sale_busy", busy, 0);

    // Change only, with a stray ticket edge.
    d0 = done_seen;
    do_start(0, 1);
    check_val("chg_hopper_en", {tkt_en, hopper_en}, 2'b01);
    pulse(0, 1);
    tick(8);
    check_val("chg_stray_ignored", {tickets_left, coins_left}, 11'h001);
    pulse(1, 1);
    tick(8);
    check_val("chg_done_count", done_seen - d0, 1);

    // Held sensor counts once; start in TICKET is ignored.
    do_start(3, 0);
    tick(5);
    pulse(0, 10);
    tick(5);
    check_val("held_once", tickets_left, 2);
    do_start(5, 9);
    check_val("start_ignored", {tickets_left, coins_left}, {3'd2, 8'd0});
    tick(5); pulse(0, 1); tick(10); pulse(0, 1); tick(10);
    check_val("ticket_finish", busy, 0);

    // Coin timeout after one confirmed coin.
    d0 = done_seen;
    do_start(0, 5);
    tick(10);
    pulse(1, 1);
    tick(52);
    check_val("pre_timeout", fault, 0);
    tick(1);
    check_val("timeout_fault", {fault, fault_code, hopper_en}, {1'b1, 2'b10, 1'b0});
    check_val("timeout_coins", coins_left, 4);
    clear = 1'b1; tick(1); clear = 1'b0;
    check_val("clear_state", {fault, fault_code, busy, coins_left}, 12'd0);
    tick(3);
    check_val("clear_no_done", done_seen - d0, 0);

    // Confirmation on the timeout cycle wins; one cycle later faults.
    do_start(0, 3);
    tick(46);
    coin_sense = 1'b1; tick(1); coin_sense = 1'b0;
    tick(3);
    check_val("edge_on_timeout", {fault, coins_left}, 9'd2);
    tick(47);
    coin_sense = 1'b1; tick(1); coin_sense = 1'b0;
    tick(2);
    check_val("edge_late_fault", {fault, fault_code, coins_left}, {1'b1, 2'b10, 8'd2});
    clear = 1'b1; tick(1); clear = 1'b0;
    tick(2);

    // Asynchronous reset in the middle of a payout.
    do_start(0, 9);
    repeat (2) begin pulse(1, 1); tick(5); end
    tick(5);
    check_val("pre_reset_coins", coins_left, 7);
    #2 rst = 1'b1;
    #1 check_val("async_reset", {hopper_en, busy, coins_left}, 10'd0);
    tick(2);
    rst = 1'b0;
    tick(2);
    check_val("post_reset_idle", busy, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 24) == 0);
      ticket_cnt = 3'($urandom_range(0, 7));
      change_amt = 8'($urandom_range(0, 12));
      tkt_sense  = tkt_sense ? ($urandom_range(0, 1) == 1)
                             : ($urandom_range(0, (i < 2000) ? 10 : 45) == 0);
      coin_sense = coin_sense ? ($urandom_range(0, 1) == 1)
                              : ($urandom_range(0, (i < 2000) ? 10 : 45) == 0);
      clear      = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 799) == 0);
      tick(1);
    end
    start = 0; tkt_sense = 0; coin_sense = 0; clear = 0; rst = 0;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
